// File: rtl/kyber_pkg.sv
// Shared types and constants for the baby-Kyber decryption core (n=4, k=2, q=17).
package kyber_pkg;
   localparam int DATA_W      = 32;
   localparam int KYBER_N     = 4;
   localparam int KYBER_K     = 2;
   localparam int KYBER_Q     = 17;
   localparam int KYBER_QHALF = 9;

   typedef logic signed [DATA_W-1:0] coeff_t;
   typedef coeff_t [KYBER_N-1:0]     poly_t;
   typedef logic signed [15:0]       acc_t;

   typedef enum logic [1:0] {IDLE, MAC, DECODE, DONE} dec_state_e;
endpackage

// File: rtl/kyber_decrypt_core_if.sv
// Ciphertext/key input handshake and decoded-message output handshake.
interface kyber_decrypt_core_if;
   import kyber_pkg::*;

   logic              in_valid;
   logic              in_ready;
   poly_t [1:0][1:0]  ciphertext;   // [0][i] = u[i], [1][0] = v, [1][1] unused
   poly_t [1:0]       secret_key;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       message;
   logic              busy;

   modport master (
      output in_valid, ciphertext, secret_key, out_ready,
      input  in_ready, out_valid, message, busy
   );

   modport slave (
      input  in_valid, ciphertext, secret_key, out_ready,
      output in_ready, out_valid, message, busy
   );
endinterface

// File: rtl/mod_q_reduce.sv
// Combinational reduction of a signed value into the canonical range [0, Q-1].
module mod_q_reduce #(
   parameter int W  = 32,
   parameter int Q  = 17,
   parameter int QW = $clog2(Q)
) (
   input  logic signed [W-1:0] i_x,
   output logic [QW-1:0]       o_r
);
   localparam logic signed [W-1:0] QS = W'(Q);

   logic signed [W-1:0] w_rem;
   logic signed [W-1:0] w_fix;

   // Signed % keeps the dividend's sign, so one conditional add of Q suffices.
   always_comb begin
      w_rem = i_x % QS;
      w_fix = (w_rem < 0) ? w_rem + QS : w_rem;
      o_r   = QW'(w_fix);
   end
endmodule

// File: rtl/kyber_decrypt_core.sv
// Baby-Kyber decryption: w = v - s^T.u over Z_q[x]/(x^4+1), one MAC row per cycle, 4-bit decode.
// state  | meaning
// IDLE   | ready for ciphertext; captures normalised u, v, s on handshake
// MAC    | cnt 0..7: accumulate row m=cnt[1:0] of key poly k=cnt[2]
// DECODE | w = v - acc, threshold into message, raise out_valid
// DONE   | hold message until out_ready
module kyber_decrypt_core
   import kyber_pkg::*;
#(
   parameter int Q = KYBER_Q
) (
   input logic                 clk,
   input logic                 rst_n,
   kyber_decrypt_core_if.slave bus
);
   localparam int QW = $clog2(Q);
   localparam logic [QW-1:0] W_LO = QW'(Q / 4);
   localparam logic [QW-1:0] W_HI = QW'(Q - Q / 4);

   dec_state_e r_state, w_state_nxt;
   logic [2:0]                r_cnt;
   logic [1:0][3:0][QW-1:0]   r_u, r_s, w_u_n, w_s_n;
   logic [3:0][QW-1:0]        r_v, r_acc, w_v_n, w_w;
   logic [3:0]                r_msg, w_msg;
   logic                      r_out_valid;
   logic                      w_k;
   logic [1:0]                w_m, w_idx;
   acc_t                      w_t, w_a, w_b, w_prod, w_sum;
   acc_t [3:0]                w_diff;
   logic [QW-1:0]             w_acc_nxt;
   logic                      w_unused_ct;

   assign w_unused_ct = ^bus.ciphertext[1][1];

   for (genvar k = 0; k < 2; k++) begin : g_norm_k
      for (genvar j = 0; j < 4; j++) begin : g_norm_j
         mod_q_reduce #(.W(DATA_W), .Q(Q)) u_norm_u (.i_x(bus.ciphertext[0][k][j]), .o_r(w_u_n[k][j]));
         mod_q_reduce #(.W(DATA_W), .Q(Q)) u_norm_s (.i_x(bus.secret_key[k][j]),    .o_r(w_s_n[k][j]));
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_coef
      mod_q_reduce #(.W(DATA_W), .Q(Q)) u_norm_v (.i_x(bus.ciphertext[1][0][i]), .o_r(w_v_n[i]));
      assign w_diff[i] = acc_t'(r_v[i]) - acc_t'(r_acc[i]);
      mod_q_reduce #(.W(16), .Q(Q)) u_red_w (.i_x(w_diff[i]), .o_r(w_w[i]));
      // w[0] lands in the MSB of the nibble
      assign w_msg[3-i] = (w_w[i] > W_LO) && (w_w[i] < W_HI);
   end

   // Negacyclic row: coefficient m of s_k * u_k, terms that wrap past x^3 flip sign.
   always_comb begin
      w_k    = r_cnt[2];
      w_m    = r_cnt[1:0];
      w_t    = '0;
      w_idx  = '0;
      w_a    = '0;
      w_b    = '0;
      w_prod = '0;
      for (int j = 0; j < 4; j++) begin
         w_idx  = w_m - 2'(j);
         w_a    = acc_t'(r_s[w_k][j]);
         w_b    = acc_t'(r_u[w_k][w_idx]);
         w_prod = w_a * w_b;
         if (2'(j) > w_m) w_t = w_t - w_prod;
         else             w_t = w_t + w_prod;
      end
      w_sum = acc_t'(r_acc[w_m]) + w_t;
   end

   mod_q_reduce #(.W(16), .Q(Q)) u_red_acc (.i_x(w_sum), .o_r(w_acc_nxt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_state_nxt = MAC;
         MAC:     if (r_cnt == 3'd7) w_state_nxt = DECODE;
         DECODE:                     w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default:                    w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_u         <= '0;
         r_s         <= '0;
         r_v         <= '0;
         r_acc       <= '0;
         r_msg       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_u   <= w_u_n;
               r_s   <= w_s_n;
               r_v   <= w_v_n;
               r_acc <= '0;
               r_cnt <= '0;
            end
            MAC: begin
               r_acc[w_m] <= w_acc_nxt;
               r_cnt      <= r_cnt + 3'd1;
            end
            DECODE: begin
               r_msg       <= w_msg;
               r_out_valid <= 1'b1;
            end
            DONE: if (bus.out_ready) r_out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.message   = {28'd0, r_msg};
endmodule

// File: tb/tb_kyber_decrypt_core.sv
// Bench for kyber_decrypt_core: directed vector table, corner sequences, randomized model check.
module tb_kyber_decrypt_core;
   import kyber_pkg::*;

   typedef struct packed {
      logic [1:0][3:0][31:0] u;
      logic [1:0][3:0][31:0] s;
      logic [3:0][31:0]      v;
      logic [3:0]            exp;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   kyber_decrypt_core_if bus();

   kyber_decrypt_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic drive(input vec_t t);
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 4; j++) begin
            bus.ciphertext[0][k][j] = t.u[k][j];
            bus.secret_key[k][j]    = t.s[k][j];
         end
      for (int j = 0; j < 4; j++) begin
         bus.ciphertext[1][0][j] = t.v[j];
         bus.ciphertext[1][1][j] = $urandom;
      end
   endtask

   task automatic scramble();
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            for (int j = 0; j < 4; j++) bus.ciphertext[a][b][j] = $urandom;
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 4; j++) bus.secret_key[k][j] = $urandom;
   endtask

   function automatic int nq(input int x);
      return ((x % 17) + 17) % 17;
   endfunction

   // Reference: full polynomial product folded with x^4 = -1, then threshold decode.
   function automatic logic [3:0] model(input vec_t t);
      int c[4];
      int a_c, b_c, w;
      logic [3:0] m;
      for (int i = 0; i < 4; i++) c[i] = 0;
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
               a_c = t.s[k][a];
               b_c = t.u[k][b];
               if (a + b < 4) c[a+b]   += nq(a_c) * nq(b_c);
               else           c[a+b-4] -= nq(a_c) * nq(b_c);
            end
      m = '0;
      for (int i = 0; i < 4; i++) begin
         a_c = t.v[i];
         w = nq(nq(a_c) - c[i]);
         m[3-i] = (w > 17 / 4) && (w < 17 - 17 / 4);
      end
      return m;
   endfunction

   task automatic transact(input vec_t t, input logic [3:0] req, input string nm,
                           input int hold, input bit tied);
      int n;
      @(negedge clk);
      drive(t);
      bus.out_ready = tied;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      scramble();
      chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd9);
      chk({nm, "_msg"}, 64'(bus.message), {60'd0, req});
      for (int c = 0; c < hold; c++) begin
         bus.in_valid = 1'b1;
         scramble();
         @(posedge clk); #1;
         chk({nm, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
         chk({nm, "_hold_msg"}, 64'(bus.message), {60'd0, req});
         chk({nm, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_release_valid"}, 64'(bus.out_valid), 64'd0);
      chk({nm, "_release_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      vec_t tbl[6];
      vec_t t;
      int   val;

      for (int i = 0; i < 6; i++) tbl[i] = '0;
      tbl[0].v = {32'd0, 32'd9, 32'd0, 32'd9};                       tbl[0].exp = 4'hA;
      tbl[1].v = {32'd13, 32'd12, 32'd5, 32'd4};                     tbl[1].exp = 4'h6;
      tbl[2].v = {32'd0, 32'd26, -32'sd17, -32'sd8};                 tbl[2].exp = 4'hA;
      tbl[3].s[0][1] = 32'd1; tbl[3].u[0][3] = 32'd1; tbl[3].v[0] = 32'd8; tbl[3].exp = 4'h8;
      tbl[4].s[0][0] = 32'd1; tbl[4].s[1][0] = 32'd1;
      tbl[4].u[0][0] = 32'd3; tbl[4].u[1][0] = 32'd4; tbl[4].v[0] = 32'd16; tbl[4].exp = 4'h8;
      tbl[5].v = {32'd13, 32'd0, 32'h8000_0000, 32'd17009};          tbl[5].exp = 4'hC;

      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.ciphertext = '0;
      bus.secret_key = '0;

      #12;
      chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_busy",      64'(bus.busy),      64'd0);
      chk("reset_message",   64'(bus.message),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         transact(tbl[i], tbl[i].exp, $sformatf("vec%0d", i), 0, 1'b0);

      // Backpressure: result held for 5 cycles while a second request is offered.
      transact(tbl[0], tbl[0].exp, "bp", 5, 1'b0);
      @(posedge clk); #1;
      chk("bp_no_second_result", 64'(bus.out_valid), 64'd0);
      chk("bp_idle",             64'(bus.busy),      64'd0);
      chk("bp_msg_kept",         64'(bus.message),   64'hA);

      // Reset while cnt == 3.
      @(negedge clk);
      drive(tbl[3]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_busy",      64'(bus.busy),      64'd0);
      chk("midrst_message",   64'(bus.message),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_no_output", 64'(bus.out_valid), 64'd0);
      transact(tbl[4], tbl[4].exp, "after_rst", 0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         t = '0;
         for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++) begin
               val = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
               t.u[k][j] = val;
               val = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
               t.s[k][j] = val;
            end
         for (int j = 0; j < 4; j++) begin
            val = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            t.v[j] = val;
         end
         transact(t, model(t), $sformatf("rnd%0d", r), 0, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
